// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture decoder: glyph table, segment order, FSM states.
// Build option SEG7_BLANK_EN (see seg7_pattern_decode) changes how the all-off pattern decodes.
package seg7_pkg;

    localparam int unsigned SEG_W             = 7;
    localparam int unsigned NUM_GLYPHS        = 16;
    localparam int unsigned STABLE_CYCLES_DEF = 4;
    localparam int unsigned CNT_W             = 8;

    // Bit position of each segment within seg_n; A is the MSB.
    typedef enum int unsigned {
        SEG_G = 0, SEG_F = 1, SEG_E = 2, SEG_D = 3, SEG_C = 4, SEG_B = 5, SEG_A = 6
    } seg_idx_e;

    localparam logic [SEG_W-1:0] SEG_ALL_OFF = '1;

    // Active-low {A..G}, indexed by the hex value each pattern displays.
    localparam logic [SEG_W-1:0] GLYPH [NUM_GLYPHS] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_capture_decoder_if.sv
// Output handshake of the capture decoder; out_blank exists only when SEG7_BLANK_EN is defined.
interface seg7_capture_decoder_if;

    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_digit;
    logic [3:0] out_value;
    logic       out_err;
`ifdef SEG7_BLANK_EN
    logic       out_blank;

    modport master (output out_valid, out_digit, out_value, out_err, out_blank, input out_ready);
    modport slave  (input out_valid, out_digit, out_value, out_err, out_blank, output out_ready);
`else
    modport master (output out_valid, out_digit, out_value, out_err, input out_ready);
    modport slave  (input out_valid, out_digit, out_value, out_err, output out_ready);
`endif

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to hex decoder.
// With SEG7_BLANK_EN the all-off pattern is a legal blank glyph; otherwise it is an error.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg_n,
    output logic [3:0]       value,
    output logic             err,
    output logic             blank
);

    always_comb begin
        value = '0;
        err   = 1'b1;
        blank = 1'b0;
        for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
            if (seg_n == GLYPH[i]) begin
                value = 4'(i);
                err   = 1'b0;
            end
        end
        if (seg_n == SEG_ALL_OFF) begin
            blank = 1'b1;
`ifdef SEG7_BLANK_EN
            err   = 1'b0;
`endif
        end
    end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Captures a digit from a multiplexed 7-segment display once strobe and pattern are stable.
// Build option SEG7_BLANK_EN: all-off pattern decodes as a blank digit and drives out_blank.
module seg7_capture_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEG_W-1:0]       seg_n,
    input  logic [3:0]             dig_en,
    seg7_capture_decoder_if.master out_if,
    output logic                   ovf
);

    localparam logic [CNT_W-1:0] STB = CNT_W'(STABLE_CYCLES);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         dig_smp_q, dig_prv_q;
    logic [SEG_W-1:0]   seg_smp_q, seg_prv_q;
    logic               valid_q, valid_d;
    logic [1:0]         digit_q, digit_d;
    logic [3:0]         value_q, value_d;
    logic               err_q, err_d;
    logic               ovf_q, ovf_d;
    logic               capture;
    logic               legal;
    logic               same;
    logic [3:0]         dec_value;
    logic               dec_err;
    logic               dec_blank;

    seg7_pattern_decode u_decode (
        .seg_n (seg_smp_q),
        .value (dec_value),
        .err   (dec_err),
        .blank (dec_blank)
    );

    assign legal = is_onehot4(dig_smp_q);
    assign same  = ({dig_smp_q, seg_smp_q} == {dig_prv_q, seg_prv_q});

    // Capture fires in the cycle the dwell count reaches STB, which with STB=1 is the first legal sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (legal) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_SETTLE, ST_HOLD: begin
                if (!same) begin
                    state_d = legal ? ST_SETTLE : ST_IDLE;
                    cnt_d   = legal ? CNT_W'(1) : '0;
                end else if (state_q == ST_SETTLE) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d == ST_SETTLE && cnt_d == STB) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
    end

    always_comb begin
        valid_d = valid_q;
        digit_d = digit_q;
        value_d = value_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        if (capture) begin
            if (!valid_q || out_if.out_ready) begin
                valid_d = 1'b1;
                digit_d = onehot_index(dig_smp_q);
                value_d = dec_value;
                err_d   = dec_err;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && out_if.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dig_smp_q <= '0;
            seg_smp_q <= '0;
            dig_prv_q <= '0;
            seg_prv_q <= '0;
            valid_q   <= 1'b0;
            digit_q   <= '0;
            value_q   <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dig_smp_q <= dig_en;
            seg_smp_q <= seg_n;
            dig_prv_q <= dig_smp_q;
            seg_prv_q <= seg_smp_q;
            valid_q   <= valid_d;
            digit_q   <= digit_d;
            value_q   <= value_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef SEG7_BLANK_EN
    logic blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (capture && (!valid_q || out_if.out_ready)) begin
            blank_d = dec_blank;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign out_if.out_blank = blank_q;
`else
    logic unused_blank;
    assign unused_blank = dec_blank;
`endif

    assign out_if.out_valid = valid_q;
    assign out_if.out_digit = digit_q;
    assign out_if.out_value = value_q;
    assign out_if.out_err   = err_q;
    assign ovf              = ovf_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with a scoreboard of expected captures.
// Works with or without SEG7_BLANK_EN defined.
module tb_seg7_capture_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_n;
    logic [3:0] dig_en;
    logic       ovf;
    logic       ovf1;

    seg7_capture_decoder_if dif ();
    seg7_capture_decoder_if dif1 ();

    seg7_capture_decoder #(.STABLE_CYCLES(4)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .seg_n  (seg_n),
        .dig_en (dig_en),
        .out_if (dif),
        .ovf    (ovf)
    );

    seg7_capture_decoder #(.STABLE_CYCLES(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .seg_n  (seg_n),
        .dig_en (dig_en),
        .out_if (dif1),
        .ovf    (ovf1)
    );

    always #5 clk = ~clk;

`ifdef SEG7_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] digit;
        logic [3:0] value;
        logic       err;
        logic       blank;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   hs_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
        dig_en = d;
        seg_n  = s;
        step(n);
    endtask

    task automatic push(input logic [1:0] d, input logic [3:0] v, input logic e, input logic b);
        exp_t x;
        x.digit = d;
        x.value = v;
        x.err   = e;
        x.blank = b;
        sb.push_back(x);
    endtask

    // Every accepted transfer must match the oldest expected capture.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && dif.out_valid && dif.out_ready) begin
            hs_count++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=digit %0d value %0h expected=no transfer",
                       dif.out_digit, dif.out_value);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_digit", dif.out_digit, e.digit);
                check("sb_value", dif.out_value, e.value);
                check("sb_err",   dif.out_err,   e.err);
`ifdef SEG7_BLANK_EN
                check("sb_blank", dif.out_blank, e.blank);
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : stim
        int hs0;
        rst            = 1'b1;
        dig_en         = 4'b0000;
        seg_n          = 7'b1111111;
        dif.out_ready  = 1'b1;
        dif1.out_ready = 1'b1;
        step(2);

        check("rst_valid", dif.out_valid, 0);
        check("rst_digit", dif.out_digit, 0);
        check("rst_value", dif.out_value, 0);
        check("rst_err",   dif.out_err,   0);
        check("rst_ovf",   ovf,           0);
`ifdef SEG7_BLANK_EN
        check("rst_blank", dif.out_blank, 0);
`endif
        rst = 1'b0;
        step(2);

        // Digit 2 showing '3' for six cycles: exactly one transfer.
        hs0 = hs_count;
        push(2'd2, 4'h3, 1'b0, 1'b0);
        drive(4'b0100, 7'b0000110, 4);
        check("dwell_before", dif.out_valid, 0);
        step(1);
        check("dwell_valid", dif.out_valid, 1);
        check("dwell_digit", dif.out_digit, 2);
        check("dwell_value", dif.out_value, 3);
        step(1);
        check("dwell_pulse", dif.out_valid, 0);
        drive(4'b0000, 7'b1111111, 3);
        check("dwell_count", hs_count - hs0, 1);

        // Pattern changing every 3 cycles never settles.
        hs0 = hs_count;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001, 7'b0000001, 3);
            drive(4'b0001, 7'b1001111, 3);
        end
        drive(4'b0000, 7'b1111111, 3);
        check("toggle_none", hs_count - hs0, 0);
        check("toggle_valid", dif.out_valid, 0);

        // Multi-hot and zero strobes never capture.
        hs0 = hs_count;
        drive(4'b0011, 7'b0000001, 6);
        drive(4'b0000, 7'b0000001, 6);
        check("multihot_none", hs_count - hs0, 0);

        // Unmatched pattern on digit 3.
        hs0 = hs_count;
        push(2'd3, 4'h0, 1'b1, 1'b0);
        drive(4'b1000, 7'b1110111, 5);
        drive(4'b0000, 7'b1111111, 3);
        check("unmatched_count", hs_count - hs0, 1);

        // Overflow while full, then replace-on-accept.
        dif.out_ready = 1'b0;
        push(2'd0, 4'h7, 1'b0, 1'b0);
        drive(4'b0001, 7'b0001111, 5);
        check("full_valid", dif.out_valid, 1);
        check("full_ovf0",  ovf,           0);
        drive(4'b0010, 7'b0000000, 5);
        check("ovf_valid", dif.out_valid, 1);
        check("ovf_digit", dif.out_digit, 0);
        check("ovf_value", dif.out_value, 7);
        check("ovf_set",   ovf,           1);
        drive(4'b0000, 7'b0000000, 2);
        push(2'd1, 4'h8, 1'b0, 1'b0);
        drive(4'b0010, 7'b0000000, 4);
        dif.out_ready = 1'b1;
        step(1);
        check("swap_valid", dif.out_valid, 1);
        check("swap_digit", dif.out_digit, 1);
        check("swap_value", dif.out_value, 8);
        check("swap_ovf",   ovf,           1);
        drive(4'b0000, 7'b1111111, 3);
        check("swap_drain", dif.out_valid, 0);
        check("ovf_sticky", ovf,           1);

        // Reset at dwell count 3 discards progress and clears ovf.
        drive(4'b0100, 7'b0100100, 4);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", dif.out_valid, 0);
        check("mid_rst_ovf",   ovf,           0);
        step(1);
        rst = 1'b0;
        push(2'd2, 4'h5, 1'b0, 1'b0);
        step(4);
        check("redwell_before", dif.out_valid, 0);
        step(1);
        check("redwell_valid", dif.out_valid, 1);
        check("redwell_value", dif.out_value, 5);
        drive(4'b0000, 7'b1111111, 3);

        // STABLE_CYCLES=1 captures on the first legal sample.
        drive(4'b0010, 7'b0001000, 1);
        drive(4'b0000, 7'b1111111, 1);
        check("s1_valid", dif1.out_valid, 1);
        check("s1_digit", dif1.out_digit, 1);
        check("s1_value", dif1.out_value, 4'hA);
        check("s1_err",   dif1.out_err,   0);
        check("s1_main_quiet", dif.out_valid, 0);
        step(2);

        // All-off pattern: blank glyph or error depending on build.
        push(2'd0, 4'h0, !BLANK_EN, BLANK_EN);
        drive(4'b0001, 7'b1111111, 5);
        check("blank_err", dif.out_err, !BLANK_EN);
`ifdef SEG7_BLANK_EN
        check("blank_flag", dif.out_blank, 1);
`endif
        drive(4'b0000, 7'b1111111, 3);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_capture_decoder.md
SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4 (range 1..255): consecutive identical samples required before a capture.
REQ-002 clk  input  1  single clock; all state rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg_n  input  7  segment lines {A,B,C,D,E,F,G}, active-low (0 = lit).
REQ-005 dig_en  input  4  digit strobes of a multiplexed 4-digit display, active-high, legal when one-hot.
REQ-006 out_valid  output  1  a captured digit is held.
REQ-007 out_ready  input  1  consumer accepts the held digit.
REQ-008 out_digit  output  2  index of the strobed digit (dig_en bit position).
REQ-009 out_value  output  4  decoded hex value 0x0-0xF.
REQ-010 out_err  output  1  held pattern matched no glyph (out_value = 0).
REQ-011 ovf  output  1  sticky: a capture was lost because the output register was full.

Function
REQ-012 Glyph table, active-low {A..G}: 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000.
REQ-013 Inputs registered once before use; all latencies below count from the registered sample.
REQ-014 FSM states: IDLE (no legal strobe), SETTLE (counting stability), HOLD (captured, awaiting change).
REQ-015 IDLE -> SETTLE when dig_en is one-hot; counter loads 1.
REQ-016 SETTLE: counter increments while {dig_en, seg_n} equals the previous sample; any change reloads counter to 1 (stay SETTLE if one-hot, else IDLE).
REQ-017 SETTLE -> HOLD on the cycle counter reaches STABLE_CYCLES; capture occurs in that cycle; STABLE_CYCLES=1 captures on first legal sample.
REQ-018 HOLD: no further capture; any change of dig_en or seg_n -> SETTLE (one-hot) or IDLE (zero/multi-hot).
REQ-019 Capture loads out_digit/out_value/out_err and sets out_valid the next cycle; outputs stable while out_valid=1 and out_ready=0.
REQ-020 out_valid clears the cycle after out_valid & out_ready, unless a capture coincides.
REQ-021 Capture with out_valid=1 and out_ready=1 in the same cycle: new digit loaded, out_valid stays 1, ovf unchanged.
REQ-022 Capture with out_valid=1 and out_ready=0: capture dropped, held data kept, ovf set.
REQ-023 Zero or multi-hot dig_en never produces a capture.

Reset
REQ-024 rst asserted: FSM IDLE, counter 0, out_valid 0, out_digit 0, out_value 0, out_err 0, ovf 0, input sample registers 0.
REQ-025 rst mid-SETTLE or with out_valid=1 discards all progress and held data; ovf clears only by reset.

Configuration
REQ-026 SEG7_BLANK_EN defined: all-off pattern 1111111 is a legal glyph decoded as out_value 0, out_err 0, and adds output out_blank (1 bit, reset 0) set with that capture.
REQ-027 SEG7_BLANK_EN undefined: 1111111 treated as any unmatched pattern (out_err 1); out_blank absent.

Structure
REQ-028 Package seg7_pkg holds: glyph constants, segment-order definition, FSM state enum, STABLE_CYCLES default, counter width.
REQ-029 Combinational sub-module seg7_pattern_decode (seg_n -> value, err, blank) instantiated once.

Verification
REQ-030 STABLE_CYCLES=4, dig_en=0100, seg_n=0000110 held 6 cycles, out_ready=1 -> one capture: out_digit=2, out_value=3, out_err=0, single out_valid pulse.
REQ-031 seg_n toggles every 3 cycles with dig_en=0001 -> no capture, out_valid stays 0.
REQ-032 seg_n=1110111 stable on dig_en=1000 -> out_digit=3, out_value=0, out_err=1.
REQ-033 out_ready=0, two digits (dig_en 0001 then 0010, value 7 then 8) each stable 5 cycles -> holds digit 0 value 7, ovf=1; out_ready=1 with simultaneous capture -> digit 1 value 8 loaded, out_valid stays 1.
REQ-034 rst pulse during SETTLE at count 3 -> no capture; after release a fresh 4-cycle dwell is required.
REQ-035 SEG7_BLANK_EN both ways, seg_n=1111111 stable -> defined: out_blank=1, out_err=0; undefined: out_err=1.
